stl_onehot_enc_pipe: RTL and testbench

Parametrised, registered successor to the combinational one-hot-to-binary encoder. It accepts a request vector over a valid/ready handshake and returns one registered binary index per accepted vector. Selectable mode: strict one-hot check, LSB priority, MSB priority, or round-robin. It also flags zero-hot and multi-hot inputs and keeps a saturating error count. Used wherever arbitration grants or sort results are turned into indices ahead of registered datapaths.

---
 rtl/stl_enc_pkg.sv | 27 ++
 rtl/stl_onehot_enc_pipe_chk.sv | 39 +++
 rtl/stl_onehot_enc_pipe_prio.sv | 22 ++
 rtl/stl_onehot_enc_pipe.sv | 133 +++++++++++++
 tb/tb_stl_onehot_enc_pipe.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/stl_enc_pkg.sv
// Shared types and helpers for the pipelined one-hot / priority encoder.
package stl_enc_pkg;

  typedef enum logic [1:0] {
    ENC_STRICT = 2'd0,
    ENC_LSB    = 2'd1,
    ENC_MSB    = 2'd2,
    ENC_RR     = 2'd3
  } enc_mode_e;

  // Widest request vector the popcount helper can take.
  localparam int ENC_MAXW = 256;

  function automatic int f_binw(input int ohtw);
    return (ohtw > 1) ? $clog2(ohtw) : 1;
  endfunction

  function automatic logic f_binw_ok(input int ohtw, input int binw);
    return ((64'd1 << binw) >= 64'(ohtw));
  endfunction

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic f_popcnt_gt1(input logic [ENC_MAXW-1:0] vec);
    return (vec & (vec - {{(ENC_MAXW-1){1'b0}}, 1'b1})) != {ENC_MAXW{1'b0}};
  endfunction

endpackage

// File: rtl/stl_onehot_enc_pipe_chk.sv
// Protocol and result properties for stl_onehot_enc_pipe, observed on its ports.
module stl_onehot_enc_pipe_chk
  import stl_enc_pkg::*;
#(
  parameter int OHTW = 16,
  parameter int BINW = f_binw(OHTW),
  parameter int MODE = 0
) (
  input logic            clk,
  input logic            rst,
  input logic            in_valid,
  input logic            in_ready,
  input logic [OHTW-1:0] onehot_i,
  input logic            out_valid,
  input logic            out_ready,
  input logic [BINW-1:0] bin_o,
  input logic            hot_o,
  input logic            multi_o
);

  logic [OHTW-1:0] w_one;
  logic            w_accept;
  logic            w_single;

  assign w_one    = OHTW'(1);
  assign w_accept = in_valid && in_ready;
  assign w_single = (|onehot_i) && !f_popcnt_gt1(ENC_MAXW'(onehot_i));

  a_strict_onehot: assert property (@(posedge clk) disable iff (rst)
    (MODE == 0 && w_accept && w_single) |=> ($past(onehot_i) == (w_one << bin_o)));

  a_bin_range: assert property (@(posedge clk) disable iff (rst)
    out_valid |-> (int'(bin_o) < OHTW));

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=>
      (out_valid && $stable(bin_o) && $stable(hot_o) && $stable(multi_o)));

endmodule

// File: rtl/stl_onehot_enc_pipe_prio.sv
// Combinational priority index finder: lowest or highest set bit of a vector.
module stl_prio_idx #(
  parameter int OHTW = 16,
  parameter int BINW = 4
) (
  input  logic [OHTW-1:0] i_vec,
  input  logic            i_msb,
  output logic [BINW-1:0] o_idx,
  output logic            o_found
);

  // Scan upward; in MSB direction every later hit overrides, in LSB only the first counts.
  always_comb begin
    o_idx   = {BINW{1'b0}};
    o_found = 1'b0;
    for (int i = 0; i < OHTW; i++) begin
      o_idx   = (i_vec[i] && (i_msb || !o_found)) ? BINW'(i) : o_idx;
      o_found = o_found || i_vec[i];
    end
  end

endmodule

// File: rtl/stl_onehot_enc_pipe.sv
// Registered one-hot / LSB / MSB / round-robin encoder behind a valid/ready
// handshake, with hot/multi flags and a saturating illegal-input counter.
module stl_onehot_enc_pipe
  import stl_enc_pkg::*;
#(
  parameter int OHTW = 16,
  parameter int BINW = f_binw(OHTW),
  parameter int MODE = 0,
  parameter int ECW  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OHTW-1:0] onehot_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BINW-1:0] bin_o,
  output logic            hot_o,
  output logic            multi_o,
  output logic [ECW-1:0]  err_cnt_o,
  input  logic            clr_err
);

  localparam enc_mode_e LP_MODE = enc_mode_e'(MODE[1:0]);

  if (!f_binw_ok(OHTW, BINW)) begin : g_bad_binw
    $error("stl_onehot_enc_pipe: BINW too narrow for OHTW");
  end
  if (OHTW < 2 || OHTW > ENC_MAXW || MODE < 0 || MODE > 3) begin : g_bad_param
    $error("stl_onehot_enc_pipe: OHTW or MODE out of range");
  end

  logic [BINW-1:0]     r_ptr;
  logic                r_out_valid;
  logic [BINW-1:0]     r_bin;
  logic                r_hot;
  logic                r_multi;
  logic [ECW-1:0]      r_err_cnt;

  logic [OHTW-1:0]     w_mask;
  logic [BINW-1:0]     w_idx_upper;
  logic [BINW-1:0]     w_idx_all;
  logic [BINW-1:0]     w_sel;
  logic                w_found_upper;
  logic                w_hot;
  logic                w_multi;
  logic                w_illegal;
  logic                w_accept;

  // Round-robin window: request bits at or above the pointer.
  always_comb begin
    w_mask = {OHTW{1'b0}};
    for (int i = 0; i < OHTW; i++) begin
      w_mask[i] = (i >= int'(r_ptr));
    end
  end

  stl_prio_idx #(.OHTW(OHTW), .BINW(BINW)) u_prio_upper (
    .i_vec   (onehot_i & w_mask),
    .i_msb   (1'b0),
    .o_idx   (w_idx_upper),
    .o_found (w_found_upper)
  );

  stl_prio_idx #(.OHTW(OHTW), .BINW(BINW)) u_prio_all (
    .i_vec   (onehot_i),
    .i_msb   (LP_MODE == ENC_MSB),
    .o_idx   (w_idx_all),
    .o_found (w_hot)
  );

  always_comb begin
    if (LP_MODE == ENC_RR && w_found_upper) begin
      w_sel = w_idx_upper;
    end else begin
      w_sel = w_idx_all;
    end
  end

  assign w_multi   = f_popcnt_gt1(ENC_MAXW'(onehot_i));
  assign w_illegal = !w_hot || ((LP_MODE == ENC_STRICT) && w_multi);
  assign in_ready  = !rst && (!r_out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;

  // Output stage: load on accept, drop valid once consumed, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_bin       <= {BINW{1'b0}};
      r_hot       <= 1'b0;
      r_multi     <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_bin       <= w_sel;
      r_hot       <= w_hot;
      r_multi     <= w_multi;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  // Saturating illegal-input counter; clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || clr_err) begin
      r_err_cnt <= {ECW{1'b0}};
    end else if (w_accept && w_illegal && (r_err_cnt != {ECW{1'b1}})) begin
      r_err_cnt <= r_err_cnt + ECW'(1);
    end else begin
      r_err_cnt <= r_err_cnt;
    end
  end

  // Round-robin pointer moves just past the granted index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= {BINW{1'b0}};
    end else if (LP_MODE == ENC_RR && w_accept && w_hot) begin
      r_ptr <= (w_sel == BINW'(OHTW - 1)) ? {BINW{1'b0}} : w_sel + BINW'(1);
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign out_valid = r_out_valid;
  assign bin_o     = r_bin;
  assign hot_o     = r_hot;
  assign multi_o   = r_multi;
  assign err_cnt_o = r_err_cnt;

endmodule

// File: tb/tb_stl_onehot_enc_pipe.sv
// Scoreboard bench: eight encoders (OHTW 16 and 10, all four modes) share one
// stimulus stream; a reference model predicts each result and counter value.
`timescale 1ns/1ps
module tb_stl_onehot_enc_pipe;

  localparam int NDUT = 8;

  typedef struct packed {
    logic [3:0] bin;
    logic       hot;
    logic       multi;
  } res_t;

  logic clk       = 1'b0;
  logic rst       = 1'b1;
  logic in_valid  = 1'b0;
  logic out_ready = 1'b0;
  logic clr_err   = 1'b0;
  logic [15:0] vec = 16'h0000;

  logic [NDUT-1:0]      in_ready_a;
  logic [NDUT-1:0]      out_valid_a;
  logic [NDUT-1:0][3:0] bin_a;
  logic [NDUT-1:0]      hot_a;
  logic [NDUT-1:0]      multi_a;
  logic [NDUT-1:0][7:0] err_a;

  res_t q [NDUT][$];
  int   m_ptr    [NDUT] = '{default: 0};
  int   m_err    [NDUT] = '{default: 0};
  int   m_err_nx [NDUT] = '{default: 0};
  bit   m_valid  [NDUT] = '{default: 1'b0};
  bit   mon_en = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int W = (g < 4) ? 16 : 10;
    localparam int E = (g < 4) ? 8 : 4;
    logic [E-1:0] err_w;

    stl_onehot_enc_pipe #(.OHTW(W), .BINW(4), .MODE(g % 4), .ECW(E)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a[g]),
      .onehot_i(vec[W-1:0]), .out_valid(out_valid_a[g]), .out_ready(out_ready),
      .bin_o(bin_a[g]), .hot_o(hot_a[g]), .multi_o(multi_a[g]),
      .err_cnt_o(err_w), .clr_err(clr_err)
    );
    assign err_a[g] = 8'(err_w);

    stl_onehot_enc_pipe_chk #(.OHTW(W), .BINW(4), .MODE(g % 4)) u_chk (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a[g]),
      .onehot_i(vec[W-1:0]), .out_valid(out_valid_a[g]), .out_ready(out_ready),
      .bin_o(bin_a[g]), .hot_o(hot_a[g]), .multi_o(multi_a[g])
    );
  end

  task automatic check(input string name, input int g, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d expected %0d", name, g, act, exp);
    end
  endtask

  function automatic int m_popcnt(input logic [15:0] v, input int w);
    int c = 0;
    for (int i = 0; i < w; i++) c += int'(v[i]);
    return c;
  endfunction

  // Reference selection straight from the mode rules.
  function automatic int m_select(input logic [15:0] v, input int w, input int mode, input int ptr);
    if (mode == 2) begin
      for (int i = w - 1; i >= 0; i--) if (v[i]) return i;
    end else if (mode == 3) begin
      for (int k = 0; k < w; k++) if (v[(ptr + k) % w]) return (ptr + k) % w;
    end else begin
      for (int i = 0; i < w; i++) if (v[i]) return i;
    end
    return 0;
  endfunction

  // One clock of stimulus; the model predicts the state after the next edge.
  task automatic cycle(input logic iv, input logic [15:0] v, input logic ordy,
                       input logic clr, input logic r);
    @(posedge clk); #1;
    for (int g = 0; g < NDUT; g++) m_err[g] = m_err_nx[g];
    rst = r; in_valid = iv; vec = v; out_ready = ordy; clr_err = clr;
    @(negedge clk); #1;
    for (int g = 0; g < NDUT; g++) begin
      int w, mode, emax, cnt, sel;
      logic rdy, acc;
      logic [15:0] vm;
      res_t e;
      w    = (g < 4) ? 16 : 10;
      mode = g % 4;
      emax = (g < 4) ? 255 : 15;
      vm   = v & ((w == 16) ? 16'hFFFF : 16'h03FF);
      rdy  = !r && (!m_valid[g] || ordy);
      check("in_ready", g, int'(in_ready_a[g]), int'(rdy));
      m_err_nx[g] = m_err[g];
      if (r) begin
        q[g].delete();
        m_valid[g] = 1'b0; m_err_nx[g] = 0; m_ptr[g] = 0;
      end else begin
        acc = iv && rdy;
        cnt = m_popcnt(vm, w);
        sel = m_select(vm, w, mode, m_ptr[g]);
        if (acc) begin
          e.bin = 4'(sel); e.hot = (cnt > 0); e.multi = (cnt > 1);
          q[g].push_back(e);
          m_valid[g] = 1'b1;
          if (mode == 3 && cnt > 0) m_ptr[g] = (sel + 1) % w;
        end else if (ordy) begin
          m_valid[g] = 1'b0;
        end
        if (clr) m_err_nx[g] = 0;
        else if (acc && (cnt == 0 || (mode == 0 && cnt > 1)) && m_err[g] < emax)
          m_err_nx[g] = m_err[g] + 1;
      end
    end
  endtask

  // Monitor: compare whatever each DUT presents against its queue head.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int g = 0; g < NDUT; g++) begin
        check("err_cnt", g, int'(err_a[g]), m_err[g]);
        check("out_valid", g, int'(out_valid_a[g]), int'(m_valid[g]));
        if (out_valid_a[g]) begin
          check("result_expected", g, int'(q[g].size() != 0), 1);
          if (q[g].size() != 0) begin
            check("bin", g, int'(bin_a[g]), int'(q[g][0].bin));
            check("hot", g, int'(hot_a[g]), int'(q[g][0].hot));
            check("multi", g, int'(multi_a[g]), int'(q[g][0].multi));
            if (out_ready) void'(q[g].pop_front());
          end
        end
      end
    end
  end

  initial begin
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;
    // Clean one-hot inputs back to back.
    cycle(1'b1, 16'h0040, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 16'h8000, 1'b1, 1'b0, 1'b0);
    // Zero and multi-hot, then clear colliding with an illegal accept.
    cycle(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 16'h0101, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 16'h0003, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    // Round-robin walk from a fresh pointer.
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'h0111, 1'b1, 1'b0, 1'b0);
    // Backpressure with a queued input waiting.
    cycle(1'b1, 16'h0004, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'h0020, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h0020, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    // Reset while a result is pending and the pointer is non-zero.
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 16'h0010, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 16'h00FF, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 16'h0200, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    // Randomised traffic.
    for (int n = 0; n < 10000; n++) begin
      logic [15:0] v;
      int kind;
      kind = $urandom_range(0, 3);
      case (kind)
        0:       v = 16'h0000;
        1:       v = 16'h0001 << $urandom_range(0, 15);
        2:       v = 16'($urandom);
        default: v = 16'($urandom) & 16'($urandom) & 16'($urandom);
      endcase
      cycle($urandom_range(0, 3) != 0, v, $urandom_range(0, 9) < 7,
            $urandom_range(0, 199) == 0, $urandom_range(0, 1999) == 0);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    @(negedge clk); #2;
    for (int g = 0; g < NDUT; g++) check("drained", g, q[g].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
